full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Single-bit full adder with registered outputs and a valid qualifier.
- Computes Sum = A xor B xor Cin and Carry = majority(A, B, Cin).
- Optional bit-serial chaining: the previous registered Carry replaces Cin, so multi-bit operands can be added LSB-first, one bit per cycle.
- Leaf arithmetic cell used by wider adders and serial datapaths; one clock domain.

Parameters:
- OUT_REG, default 1: 1 = Sum/Carry registered (1-cycle latency); 0 = Sum/Carry combinational from current inputs, while out_valid and the chain carry stay registered.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- A  input  1  addend bit.
- B  input  1  addend bit.
- Cin  input  1  external carry-in; ignored when chain_en=1 and a chain carry is held.
- in_valid  input  1  qualifies A/B/Cin/chain_en this cycle.
- chain_en  input  1  1 = use the stored carry from the previous valid operation as carry-in (serial mode).
- Sum  output  1  sum bit.
- Carry  output  1  carry-out bit.
- out_valid  output  1  Sum/Carry correspond to an accepted operation.

Behaviour:
- Reset (rst_n=0 at a rising edge): Sum=0, Carry=0, out_valid=0, internal chain carry=0. Reset overrides in_valid in the same cycle.
- Effective carry-in: cin_eff = chain_en ? carry_q : Cin, where carry_q is the Carry of the last accepted operation.
- Arithmetic is 2-bit: {Carry, Sum} = A + B + cin_eff, range 0..3. No overflow is possible.
- OUT_REG=1:
  - At a rising edge with in_valid=1, Sum/Carry register the result and out_valid=1 in the next cycle.
  - With in_valid=0, out_valid=0 next cycle and Sum/Carry hold their last values.
  - Latency is exactly 1 cycle; throughput is one operation per cycle with no stall.
- OUT_REG=0:
  - Sum/Carry follow A/B/cin_eff combinationally at all times.
  - out_valid = in_valid, gated to 0 while rst_n=0.
- carry_q updates only on accepted operations (in_valid=1); it holds when in_valid=0.
- Starting a serial word: drive chain_en=0 on the LSB so Cin seeds the chain (Cin=0 for addition). Drive chain_en=1 on subsequent bits.
- chain_en=1 on the first operation after reset uses carry_q=0.
- Reset mid-chain clears carry_q; the next chained operation sees carry-in 0.
- No X propagation from an idle Cin: when chain_en=1, Cin must not affect the outputs.

Test Plan:
- Truth table, OUT_REG=1, chain_en=0: apply ABC = 000, 001, 010, 011, 100, 101, 110, 111 on consecutive cycles with in_valid=1. One cycle later each, {Carry,Sum} = 00, 01, 01, 10, 01, 10, 10, 11; out_valid=1 throughout.
- Reset: hold rst_n=0 with A=B=Cin=1, in_valid=1 -> Sum=0, Carry=0, out_valid=0. Release rst_n -> next cycle {Carry,Sum}=11.
- Bubble: in_valid=1 with 110, then in_valid=0 with 000 -> cycle 1: {Carry,Sum}=10, out_valid=1. Cycle 2: outputs hold 10, out_valid=0.
- Serial add 0b11 + 0b01, LSB first:
  - Bit 0: A=1, B=1, Cin=0, chain_en=0 -> Sum=0, Carry=1.
  - Bit 1: A=1, B=0, chain_en=1, Cin=0 -> Sum=0, Carry=1 (result 100b).
  - Repeat bit 1 with Cin=1 and check identical outputs.
- Reset mid-chain: complete bit 0 leaving carry_q=1, pulse rst_n=0 for one cycle, then A=0, B=0, chain_en=1 -> Sum=0, Carry=0.
- OUT_REG=0: sweep all 8 ABC combinations -> Sum/Carry match the truth table in the same cycle, out_valid mirrors in_valid.

Source files
------------

// File: rtl/full_adder.sv
// Single-bit full adder with a valid qualifier and an optional bit-serial carry chain.
// OUT_REG selects registered (1-cycle latency) or combinational Sum/Carry.
module full_adder #(
  parameter int unsigned OUT_REG = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic in_valid,
  input  logic chain_en,
  output logic Sum,
  output logic Carry,
  output logic out_valid
);

  logic carry_q;
  logic cin_eff_c;
  logic sum_c;
  logic carry_c;

  // Select keeps an idle or unknown Cin from reaching the result while chaining.
  always_comb begin
    cin_eff_c = Cin;
    if (chain_en) cin_eff_c = carry_q;
  end

  always_comb begin
    {carry_c, sum_c} = 2'(A) + 2'(B) + 2'(cin_eff_c);
  end

  // Chain carry tracks the last accepted operation only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (in_valid) begin
      carry_q <= carry_c;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic sum_q;
    logic valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_q   <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) sum_q <= sum_c;
      end
    end

    // The registered carry-out is exactly the chain carry.
    assign Sum       = sum_q;
    assign Carry     = carry_q;
    assign out_valid = valid_q;
  end else begin : g_out_comb
    assign Sum       = sum_c;
    assign Carry     = carry_c;
    assign out_valid = in_valid & rst_n;
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: registered and combinational instances share stimulus
// and are compared against an arithmetic reference model of the carry chain.
module tb_full_adder;

  logic clk;
  logic rst_n;
  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic chain_en;
  logic sum_r, carry_r, valid_r;
  logic sum_n, carry_n, valid_n;

  int checks;
  int errors;

  // Reference state: stored chain carry and expected registered outputs.
  int m_carry;
  int e_sum;
  int e_carry;
  int e_valid;

  full_adder #(.OUT_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
    .in_valid(in_valid), .chain_en(chain_en),
    .Sum(sum_r), .Carry(carry_r), .out_valid(valid_r)
  );

  full_adder #(.OUT_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
    .in_valid(in_valid), .chain_en(chain_en),
    .Sum(sum_n), .Carry(carry_n), .out_valid(valid_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input int expv);
    logic e;
    e = 1'(expv);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  // One operation: drive at negedge, check combinational instance, clock, check registered one.
  task automatic step(input string tag, input logic ta, input logic tb_, input logic tc,
                      input logic tv, input logic tce, input logic tr);
    int cin_use;
    int total;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; in_valid = tv; chain_en = tce; rst_n = tr;
    cin_use = tce ? m_carry : int'(tc);
    total   = int'(ta) + int'(tb_) + cin_use;
    #1;
    chk({tag, ".comb_sum"},   sum_n,   total % 2);
    chk({tag, ".comb_carry"}, carry_n, total / 2);
    chk({tag, ".comb_valid"}, valid_n, (tv && tr) ? 1 : 0);
    @(posedge clk);
    if (!tr) begin
      e_sum = 0; e_carry = 0; e_valid = 0; m_carry = 0;
    end else if (tv) begin
      e_sum = total % 2; e_carry = total / 2; e_valid = 1; m_carry = total / 2;
    end else begin
      e_valid = 0;
    end
    #1;
    chk({tag, ".reg_sum"},   sum_r,   e_sum);
    chk({tag, ".reg_carry"}, carry_r, e_carry);
    chk({tag, ".reg_valid"}, valid_r, e_valid);
  endtask

  initial begin
    logic [2:0] abc;
    logic ra, rb, rc, rv, rce, rr;
    clk = 1'b0;
    checks = 0; errors = 0;
    m_carry = 0; e_sum = 0; e_carry = 0; e_valid = 0;
    rst_n = 1'b0; a = 1'b1; b = 1'b1; cin = 1'b1; in_valid = 1'b1; chain_en = 1'b0;

    // Reset overrides in_valid with all-ones operands.
    step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("rst_rel", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Truth table, consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      step("tt", abc[2], abc[1], abc[0], 1'b1, 1'b0, 1'b1);
    end

    // Bubble: outputs hold while out_valid drops.
    step("bub1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("bub2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("bub3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

    // Serial 0b11 + 0b01, then repeat bit 1 with Cin=1 (must be ignored).
    step("ser_b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("ser_b1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("ser_b1r", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset mid-chain clears the stored carry.
    step("mid_b0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mid_b1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Unknown Cin while chaining must not disturb the outputs.
    step("x_seed", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step("x_chain", 1'b0, 1'b1, 1'bx, 1'b1, 1'b1, 1'b1);

    // Randomized traffic with occasional bubbles, chain toggles and resets.
    for (int i = 0; i < 300; i++) begin
      ra  = 1'($urandom);
      rb  = 1'($urandom);
      rc  = 1'($urandom);
      rv  = ($urandom_range(0, 3) != 0);
      rce = 1'($urandom);
      rr  = ($urandom_range(0, 31) != 0);
      step("rnd", ra, rb, rc, rv, rce, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
